// File: rtl/if_fetch_if.sv
// Fetch-stage bundle: instruction-memory handshake, ID-stage control and the IF/ID outputs.
// The fetch unit uses the master modport; the memory/ID side uses slave.
interface if_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        flush;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] Instr;
  logic [31:0] pc_id;
  logic        valid_id;

  modport master (
    output imem_req, imem_addr, Instr, pc_id, valid_id,
    input  imem_ack, imem_rdata, stall, flush, branch_taken, branch_target
  );

  modport slave (
    input  imem_req, imem_addr, Instr, pc_id, valid_id,
    output imem_ack, imem_rdata, stall, flush, branch_taken, branch_target
  );
endinterface

// File: rtl/if_fetch.sv
// Instruction fetch stage: single outstanding request, one-entry skid buffer for ID stalls,
// and a DROP state that swallows the response of a request overtaken by a redirect.
module if_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic          clk,
  input  logic          reset,
  if_fetch_if.master    bus
);

  typedef enum logic [1:0] {FETCH, HOLD, DROP} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_f_q, pc_f_d;
  logic [31:0] redir_pc_q, redir_pc_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_id_q, pc_id_d;
  logic        valid_q, valid_d;
  logic [31:0] target;

  assign target = bus.branch_target & 32'hFFFF_FFFC;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= FETCH;
      pc_f_q       <= RESET_PC;
      redir_pc_q   <= 32'h0;
      skid_instr_q <= 32'h0;
      skid_pc_q    <= 32'h0;
      instr_q      <= NOP_INSTR;
      pc_id_q      <= 32'h0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_f_q       <= pc_f_d;
      redir_pc_q   <= redir_pc_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      instr_q      <= instr_d;
      pc_id_q      <= pc_id_d;
      valid_q      <= valid_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_f_d       = pc_f_q;
    redir_pc_d   = redir_pc_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    instr_d      = instr_q;
    pc_id_d      = pc_id_q;
    valid_d      = valid_q;

    if (bus.branch_taken) begin
      valid_d = 1'b0;
      case (state_q)
        FETCH: begin
          if (bus.imem_ack) begin
            pc_f_d = target;
          end else begin
            redir_pc_d = target;
            state_d    = DROP;
          end
        end
        DROP: begin
          // The outstanding response still has to be swallowed before the new target.
          if (bus.imem_ack) begin
            pc_f_d  = target;
            state_d = FETCH;
          end else begin
            redir_pc_d = target;
          end
        end
        HOLD: begin
          pc_f_d  = target;
          state_d = FETCH;
        end
        default: state_d = FETCH;
      endcase
    end else if (bus.flush) begin
      // A flush kills IF/ID and any buffered or arriving word; pc_f is left alone.
      valid_d = 1'b0;
      case (state_q)
        HOLD: state_d = FETCH;
        DROP: begin
          if (bus.imem_ack) begin
            pc_f_d  = redir_pc_q;
            state_d = FETCH;
          end
        end
        default: ;
      endcase
    end else begin
      case (state_q)
        FETCH: begin
          if (bus.imem_ack) begin
            pc_f_d = pc_f_q + 32'd4;
            if (!valid_q || !bus.stall) begin
              instr_d = bus.imem_rdata;
              pc_id_d = pc_f_q;
              valid_d = 1'b1;
            end else begin
              skid_instr_d = bus.imem_rdata;
              skid_pc_d    = pc_f_q;
              state_d      = HOLD;
            end
          end else if (!bus.stall) begin
            valid_d = 1'b0;
          end
        end
        HOLD: begin
          if (!bus.stall) begin
            instr_d = skid_instr_q;
            pc_id_d = skid_pc_q;
            valid_d = 1'b1;
            state_d = FETCH;
          end
        end
        DROP: begin
          if (bus.imem_ack) begin
            pc_f_d  = redir_pc_q;
            state_d = FETCH;
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

  assign bus.imem_req  = (state_q != HOLD) && !reset;
  assign bus.imem_addr = pc_f_q & 32'hFFFF_FFFC;
  assign bus.Instr     = valid_q ? instr_q : NOP_INSTR;
  assign bus.pc_id     = pc_id_q;
  assign bus.valid_id  = valid_q;

endmodule

// File: doc/if_fetch.md
IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h0000_0013, meaning the bubble instruction (addi x0,x0,0) presented on Instr when the IF/ID slot is empty.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port imem_req, output, 1 bit: fetch request.
REQ-006 SHALL have port imem_addr, output, 32 bits: word-aligned fetch address.
REQ-007 SHALL have port imem_ack, input, 1 bit: memory returns data on imem_rdata in the same cycle.
REQ-008 SHALL have port imem_rdata, input, 32 bits: fetched instruction word.
REQ-009 SHALL have port stall, input, 1 bit: ID stage holds the IF/ID register.
REQ-010 SHALL have port flush, input, 1 bit: kills the IF/ID contents.
REQ-011 SHALL have port branch_taken, input, 1 bit: redirect request.
REQ-012 SHALL have port branch_target, input, 32 bits: redirect address.
REQ-013 SHALL have port Instr, output, 32 bits: IF/ID instruction, feeding the immediate generator and decoder.
REQ-014 SHALL have port pc_id, output, 32 bits: PC of Instr.
REQ-015 SHALL have port valid_id, output, 1 bit: Instr holds a real instruction.

Function
REQ-016 SHALL hold fetch PC pc_f, redirect register redir_pc, one-entry skid buffer (instruction + PC), and an FSM with states FETCH, HOLD and DROP.
REQ-017 SHALL drive imem_req = 1 in FETCH and DROP, 0 in HOLD and while reset is high.
REQ-018 SHALL keep imem_addr = pc_f and stable while imem_req is high and imem_ack is low; imem_addr[1:0] is always 2'b00.
REQ-019 FETCH, on ack, no branch, with (!valid_id || !stall): SHALL load IF/ID with {imem_rdata, pc_f}, set valid_id = 1, set pc_f += 4 (mod 2^32), and stay in FETCH.
REQ-020 FETCH, on ack, no branch, with valid_id && stall: SHALL capture {imem_rdata, pc_f} in the skid buffer, set pc_f += 4, and go to HOLD.
REQ-021 HOLD, with !stall: SHALL move the skid buffer into IF/ID, set valid_id = 1, and go to FETCH.
REQ-022 Latency SHALL be one cycle: an ack in cycle N with ID free gives valid Instr in cycle N+1.
REQ-023 branch_taken SHALL have top priority; it clears IF/ID (valid_id = 0, Instr = NOP_INSTR) whether or not stall is high, and forces branch_target[1:0] to 0.
REQ-024 branch_taken in FETCH with ack in the same cycle: SHALL discard the response, set pc_f = target, and stay in FETCH.
REQ-025 branch_taken in FETCH without ack: SHALL latch redir_pc = target and go to DROP; imem_addr keeps the old pc_f.
REQ-026 DROP, on ack: SHALL discard imem_rdata, set pc_f = redir_pc, and go to FETCH; a new branch_taken while in DROP overwrites redir_pc.
REQ-027 branch_taken in HOLD: SHALL discard the skid buffer, set pc_f = target, and go to FETCH.
REQ-028 flush without branch: SHALL clear IF/ID (valid_id = 0) and discard the skid buffer (HOLD -> FETCH) without changing pc_f; flush wins over stall.
REQ-029 With valid_id = 1 and stall = 1, SHALL hold Instr and pc_id unchanged.
REQ-030 With valid_id = 0, SHALL drive Instr = NOP_INSTR.

Reset
REQ-031 reset high SHALL immediately and asynchronously force: pc_f = RESET_PC, state = FETCH, valid_id = 0, Instr = NOP_INSTR, pc_id = 0, redir_pc = 0, skid buffer empty.
REQ-032 In the first cycle after reset deasserts, SHALL drive imem_req = 1 with imem_addr = RESET_PC.
REQ-033 reset asserted while a request is outstanding SHALL abandon that request; a late ack is ignored while reset is high.

Verification
REQ-034 Streaming: ack every cycle, rdata = 0x00A00093 then 0x00100113, no stall -> Instr follows one cycle behind; pc_id = 0x0, then 0x4; imem_addr = 0x0, 0x4, 0x8.
REQ-035 Stall: assert stall with valid_id = 1, ack 0x00208193 at pc 0x8 -> state HOLD, imem_req = 0, Instr unchanged; stall drops -> Instr = 0x00208193, pc_id = 0x8.
REQ-036 Redirect mid-request: branch_taken with target 0x103 and no ack, ack two cycles later -> imem_addr stays at old pc, response discarded, next imem_addr = 0x100, valid_id = 0 meanwhile.
REQ-037 Simultaneous events: branch_taken + ack + stall in one cycle with target 0x40 -> valid_id = 0, Instr = 0x00000013, next imem_addr = 0x40.
REQ-038 Wrap: RESET_PC = 0xFFFFFFFC, one ack -> next imem_addr = 0x00000000.
REQ-039 Async reset mid-HOLD: reset pulse between clock edges -> outputs take reset values before the next edge; after release, imem_addr = RESET_PC.
